// File: rtl/laser_chaser_pkg.sv
// laser_chaser_pkg: frame geometry, capture FSM states and the shift-add row-base helper.
package laser_chaser_pkg;
  localparam int FRAME_W = 320;
  localparam int FRAME_H = 240;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
  localparam int ADDR_W = 17;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} cap_state_t;
  // v*w from the set bits of the constant w, so no multiplier is built
  function automatic logic [31:0] row_base(input logic [7:0] v, input int w);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 32; i++)
      if (w[i]) s = s + ({24'd0, v} << i);
    return s;
  endfunction
endpackage

// File: rtl/frame_addr_gen.sv
// frame_addr_gen: range-checked pixel to frame-buffer write, registered with 1-cycle latency.
module frame_addr_gen #(
  parameter int FRAME_W = laser_chaser_pkg::FRAME_W,
  parameter int FRAME_H = laser_chaser_pkg::FRAME_H,
  parameter int ADDR_W = laser_chaser_pkg::ADDR_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en,
  input  logic [15:0]       pixel_in,
  input  logic [8:0]        hcount_in,
  input  logic [7:0]        vcount_in,
  output logic              accept,
  output logic              we_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [15:0]       data_out
);
  assign accept = en && (32'(hcount_in) < FRAME_W) && (32'(vcount_in) < FRAME_H);
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      we_out <= 1'b0;
      addr_out <= '0;
      data_out <= '0;
    end else begin
      we_out <= accept;
      if (accept) begin
        addr_out <= ADDR_W'(laser_chaser_pkg::row_base(vcount_in, FRAME_W)) + ADDR_W'(hcount_in);
        data_out <= pixel_in;
      end
    end
  end
endmodule

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: arms, frame-aligns and validates camera capture into the frame buffer.
// Define DOUBLE_BUFFER_EN for ping-pong banks; otherwise both bank outputs are tied 0.
module frame_capture_ctrl #(
  parameter int FRAME_W = laser_chaser_pkg::FRAME_W,
  parameter int FRAME_H = laser_chaser_pkg::FRAME_H,
  parameter int ADDR_W = laser_chaser_pkg::ADDR_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              continuous_in,
  input  logic              stop_in,
  input  logic              data_valid_in,
  input  logic [15:0]       pixel_in,
  input  logic [8:0]        hcount_in,
  input  logic [7:0]        vcount_in,
  input  logic              frame_done_in,
  output logic              we_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [15:0]       data_out,
  output logic              wr_bank_out,
  output logic              rd_bank_out,
  output logic              frame_ready_out,
  output logic              busy_out,
  output logic              short_err_out,
  output logic [15:0]       frame_cnt_out
);
  import laser_chaser_pkg::*;
  localparam int PIX = FRAME_W * FRAME_H;
  localparam int CNT_W = $clog2(PIX + 1);
  localparam logic [CNT_W-1:0] PIX_C = CNT_W'(PIX);
  cap_state_t state, nxt;
  logic accept, fin, good;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  frame_addr_gen #(.FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .ADDR_W(ADDR_W)) u_addr (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .en(state == CAPTURE && data_valid_in && !stop_in),
    .pixel_in(pixel_in),
    .hcount_in(hcount_in),
    .vcount_in(vcount_in),
    .accept(accept),
    .we_out(we_out),
    .addr_out(addr_out),
    .data_out(data_out)
  );
  // the pixel accepted in the frame_done cycle is already included in cnt_nxt
  always_comb begin
    cnt_nxt = (accept && cnt != PIX_C) ? cnt + 1'b1 : cnt;
    nxt = stop_in ? IDLE :
          state == IDLE ? (start_in ? ARMED : IDLE) :
          state == ARMED ? (frame_done_in ? CAPTURE : ARMED) :
          state == CAPTURE ? (frame_done_in ? DONE : CAPTURE) :
          (continuous_in ? ARMED : IDLE);
  end
  assign fin = state == CAPTURE && nxt == DONE;
  assign good = fin && cnt_nxt == PIX_C;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt <= '0;
      frame_ready_out <= 1'b0;
      short_err_out <= 1'b0;
      busy_out <= 1'b0;
      frame_cnt_out <= '0;
    end else begin
      state <= nxt;
      cnt <= (state == CAPTURE && nxt == CAPTURE) ? cnt_nxt : '0;
      frame_ready_out <= good;
      short_err_out <= fin && !good;
      busy_out <= nxt == ARMED || nxt == CAPTURE;
      frame_cnt_out <= frame_cnt_out + {15'd0, good};
    end
  end
`ifdef DOUBLE_BUFFER_EN
  logic rd_bank;
  always_ff @(posedge clk_in) begin
    if (rst_in) rd_bank <= 1'b0;
    else rd_bank <= rd_bank ^ good;
  end
  assign rd_bank_out = rd_bank;
  assign wr_bank_out = ~rd_bank;
`else
  assign rd_bank_out = 1'b0;
  assign wr_bank_out = 1'b0;
`endif
endmodule
